// File: rtl/pendigits_frame_loader_pkg.sv
// Shared constants and types for the Pendigits frame loader.
package pendigits_pkg;

    localparam int NUM_A          = 16;
    localparam int WIDTH_A        = 4;
    localparam int OUTWIDTH       = 4;
    localparam int DEFAULT_SETTLE = 3;
    localparam int IDX_W          = $clog2(NUM_A);

    typedef enum logic {
        LOAD   = 1'b0,
        SETTLE = 1'b1
    } state_e;

endpackage

// File: rtl/pendigits_frame_loader_if.sv
// Feature stream in and class result out, grouped as one bundle.
// The loader sits on the slave side; the feeder/consumer on the master side.
interface pendigits_frame_loader_if #(
    parameter int WIDTH_A  = 4,
    parameter int OUTWIDTH = 4
);
    logic                s_valid;
    logic                s_ready;
    logic [WIDTH_A-1:0]  s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [OUTWIDTH-1:0] m_class;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class
    );
endinterface

// File: rtl/pendigits_frame_loader_settle_timer.sv
// 8-bit loadable down-counter that reports when it has reached zero.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Load takes priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 8'd0);

endmodule

// File: rtl/pendigits_frame_loader.sv
// Streams features into the classifier input vector, waits a settle time,
// then captures the classifier output onto a valid/ready result port.
//
// state  | meaning
// LOAD   | accepting feature beats into inp slots
// SETTLE | inp frozen, counting down before sampling cls_in
module pendigits_frame_loader #(
    parameter int NUM_A         = pendigits_pkg::NUM_A,
    parameter int WIDTH_A       = pendigits_pkg::WIDTH_A,
    parameter int OUTWIDTH      = pendigits_pkg::OUTWIDTH,
    parameter int SETTLE_CYCLES = pendigits_pkg::DEFAULT_SETTLE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pendigits_frame_loader_if.slave    bus,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        cls_in,
    output logic                       frame_err
);

    localparam int                LIDX_W   = $clog2(NUM_A);
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_A - 1);
    localparam logic [7:0]        SETTLE_V = 8'(SETTLE_CYCLES);

    import pendigits_pkg::*;

    state_e                     state_q, state_d;
    logic [LIDX_W-1:0]          idx_q, idx_d;
    logic [NUM_A*WIDTH_A-1:0]   inp_q, inp_d;
    logic                       m_valid_q, m_valid_d;
    logic [OUTWIDTH-1:0]        m_class_q, m_class_d;
    logic                       frame_err_q, frame_err_d;

    logic s_ready;
    logic beat;
    logic at_last;
    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    // The final slot is held off while a result is still pending, so a new
    // capture can never overwrite an unconsumed class.
    assign at_last = (idx_q == LAST_IDX);
    assign s_ready = (state_q == LOAD) && !(at_last && m_valid_q);
    assign beat    = bus.s_valid && s_ready;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (SETTLE_V),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    // Next-state, slot write decode and result register update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        inp_d       = inp_q;
        m_valid_d   = m_valid_q;
        m_class_d   = m_class_q;
        frame_err_d = 1'b0;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            LOAD: begin
                if (beat) begin
                    inp_d[idx_q*WIDTH_A +: WIDTH_A] = bus.s_data;
                    if (at_last && bus.s_last) begin
                        idx_d      = '0;
                        timer_load = 1'b1;
                        state_d    = SETTLE;
                    end else if (at_last || bus.s_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    m_class_d = cls_in;
                    m_valid_d = 1'b1;
                    state_d   = LOAD;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            inp_q       <= '0;
            m_valid_q   <= 1'b0;
            m_class_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            inp_q       <= inp_d;
            m_valid_q   <= m_valid_d;
            m_class_q   <= m_class_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_class = m_class_q;
    assign inp         = inp_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_pendigits_frame_loader.sv
// Directed and randomized bench for the Pendigits frame loader.
module tb_pendigits_frame_loader;

    localparam int NA = 16;
    localparam int WA = 4;
    localparam int SC = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NA*WA-1:0] inp;
    logic [3:0]      cls_in;
    logic            frame_err;

    int checks = 0;
    int failures = 0;

    // Reference model: frame contents by slot and position within the frame.
    logic [3:0] slots [NA];
    int         cnt;

    always #5 clk = ~clk;

    pendigits_frame_loader_if #(.WIDTH_A(WA), .OUTWIDTH(4)) bus ();

    pendigits_frame_loader #(
        .NUM_A(NA), .WIDTH_A(WA), .OUTWIDTH(4), .SETTLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .inp       (inp),
        .cls_in    (cls_in),
        .frame_err (frame_err)
    );

    function automatic logic [NA*WA-1:0] packed_slots();
        logic [NA*WA-1:0] v;
        v = '0;
        for (int i = 0; i < NA; i++) v[i*WA +: WA] = slots[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) slots[i] = 4'h0;
        cnt = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $display("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Starts and ends at a negedge. Updates the model and checks inp/frame_err.
    task automatic send_beat(input logic [3:0] d, input logic last);
        int  n;
        bit  err;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            timeout("beat_accept");
            bus.s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        slots[cnt] = d;
        err = (last && cnt < NA-1) || (!last && cnt == NA-1);
        cnt = (last || cnt == NA-1) ? 0 : cnt + 1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("beat_inp", inp, packed_slots());
        check("beat_frame_err", frame_err, err);
    endtask

    // Called at the negedge just after the final beat was accepted.
    task automatic wait_result(input logic [3:0] exp_cls);
        int n;
        logic [NA*WA-1:0] held;
        held = inp;
        n = 0;
        while (!bus.m_valid && n < 40) begin
            check("settle_inp_stable", inp, held);
            check("settle_s_ready", bus.s_ready, 1'b0);
            @(negedge clk);
            n++;
        end
        check("result_latency", n, SC + 1);
        check("result_class", bus.m_class, exp_cls);
    endtask

    task automatic consume();
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        check("consume_m_valid", bus.m_valid, 1'b0);
    endtask

    task automatic random_frame(input logic [3:0] c);
        cls_in = c;
        for (int i = 0; i < NA; i++) send_beat(4'($urandom_range(0, 15)), i == NA-1);
        wait_result(c);
    endtask

    initial begin
        logic [3:0] rc;
        int         d;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        cls_in      = 4'd0;
        model_reset();

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk);
        check("rst_hold_m_valid", bus.m_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1'b1);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_inp", inp, 64'h0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_m_class", bus.m_class, 4'd0);

        // Counting frame 0..15, class 7.
        cls_in = 4'd7;
        for (int i = 0; i < NA; i++) send_beat(4'(i), i == NA-1);
        check("count_inp", inp, 64'hFEDCBA9876543210);
        wait_result(4'd7);
        consume();

        // Short frame: framing error, no result.
        for (int i = 0; i < 6; i++) send_beat(4'($urandom_range(0, 15)), i == 5);
        @(negedge clk);
        check("short_err_one_cycle", frame_err, 1'b0);
        repeat (8) @(negedge clk);
        check("short_no_result", bus.m_valid, 1'b0);
        cls_in = 4'd3;
        for (int i = 0; i < NA; i++) send_beat(4'hA, i == NA-1);
        check("all_a_inp", inp, {NA{4'hA}});
        wait_result(4'd3);
        consume();

        // Overlap: pending class 7, second frame stalls at its final beat.
        random_frame(4'd7);
        cls_in = 4'd2;
        for (int i = 0; i < NA-1; i++) send_beat(4'($urandom_range(0, 15)), 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 4'h5;
        bus.s_last  = 1'b1;
        repeat (3) begin
            check("stall_s_ready", bus.s_ready, 1'b0);
            check("stall_m_valid", bus.m_valid, 1'b1);
            check("stall_m_class", bus.m_class, 4'd7);
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        check("handshake_m_valid", bus.m_valid, 1'b0);
        check("handshake_s_ready", bus.s_ready, 1'b1);
        @(posedge clk);
        slots[NA-1] = 4'h5;
        cnt = 0;
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("overlap_inp", inp, packed_slots());
        wait_result(4'd2);
        consume();

        // Sixteen beats without s_last.
        for (int i = 0; i < NA; i++) send_beat(4'($urandom_range(0, 15)), 1'b0);
        repeat (6) @(negedge clk);
        check("nolast_no_result", bus.m_valid, 1'b0);
        check("nolast_s_ready", bus.s_ready, 1'b1);
        random_frame(4'd9);
        consume();

        // Randomized frames with random consumer delay.
        for (int f = 0; f < 4; f++) begin
            rc = 4'($urandom_range(0, 15));
            random_frame(rc);
            d = $urandom_range(0, 3);
            repeat (d) begin
                @(negedge clk);
                check("rand_hold_class", bus.m_class, rc);
            end
            consume();
        end

        // Reset in the second settle cycle discards the frame.
        cls_in = 4'd12;
        for (int i = 0; i < NA; i++) send_beat(4'($urandom_range(1, 15)), i == NA-1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_inp", inp, 64'h0);
        check("midrst_m_valid", bus.m_valid, 1'b0);
        check("midrst_m_class", bus.m_class, 4'd0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_s_ready", bus.s_ready, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_result", bus.m_valid, 1'b0);
        random_frame(4'd4);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/pendigits_frame_loader.md
Name: pendigits_frame_loader

Overview:
Upstream feeder for the combinational Pendigits classifier `top`. It accepts features one per handshake as a stream of NUM_A features of WIDTH_A bits each. It assembles them into the flat `inp` vector and holds that vector stable for a programmable settle time. It then samples the classifier's `out` and presents the class on a valid/ready result port. Purpose: drive the classifier from a streaming source without per-frame glue logic.

Parameters:
NUM_A, 16, features per frame
WIDTH_A, 4, bits per feature
OUTWIDTH, 4, class width
SETTLE_CYCLES, 3, clock cycles inp is held stable before sampling cls_in (range 0..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  feature beat valid
s_ready  out  1  loader can accept a beat
s_data  in  WIDTH_A  feature value
s_last  in  1  marks final feature of frame
inp  out  NUM_A*WIDTH_A  feature vector to classifier (feature i at bits [(i+1)*WIDTH_A-1 : i*WIDTH_A])
cls_in  in  OUTWIDTH  classifier result (top.out)
m_valid  out  1  result valid
m_ready  in  1  result consumed
m_class  out  OUTWIDTH  captured class
frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (asynchronous, rst_n=0) sets:
  - state=LOAD, idx=0, inp=0, m_valid=0, m_class=0, frame_err=0, settle counter=0.
  - Reset asserted mid-frame or mid-settle discards everything. No m_valid follows.
- States: LOAD, SETTLE.
- s_ready = (state==LOAD) && !(idx==NUM_A-1 && m_valid). Registered terms only; no combinational path from m_ready.
- LOAD, on each beat with s_valid && s_ready:
  - inp slot idx <= s_data; the other slots are unchanged.
  - If idx<NUM_A-1 and !s_last: idx<=idx+1.
  - If idx==NUM_A-1 and s_last: idx<=0, settle counter <= SETTLE_CYCLES, state<=SETTLE.
  - If s_last with idx<NUM_A-1, or !s_last with idx==NUM_A-1: framing error.
    - frame_err=1 for exactly one cycle; idx<=0; stay in LOAD.
    - The partial frame is discarded. inp slot contents are not cleared.
    - m_valid and m_class are unaffected.
- SETTLE:
  - s_ready=0 and inp is frozen.
  - If counter!=0, decrement.
  - If counter==0:
    - m_class<=cls_in, m_valid<=1, state<=LOAD.
    - Entering SETTLE guarantees !m_valid or a consumed result, because the final beat was only accepted when !m_valid.
- Latency: m_valid rises SETTLE_CYCLES+1 clock edges after the edge that accepted the final beat. With SETTLE_CYCLES=0 it rises on the next edge.
- cls_in is sampled only on the capture edge. It is ignored at all other times (inp is partially updated during LOAD).
- Result port:
  - m_valid stays high and m_class stays constant until m_valid && m_ready.
  - m_valid then clears next cycle.
- Overlap: while a result is pending, the next frame may load beats 0..NUM_A-2. The final beat stalls (s_ready=0) until the result is consumed. If m_ready is high, s_ready reasserts on the cycle after the handshake.
- Simultaneous events: if a result handshake and a final-beat stall coincide, the handshake wins. The final beat is accepted on the following cycle.
- s_data and s_last are don't-care when s_valid=0. idx never exceeds NUM_A-1.

Decomposition:
- Shared package `pendigits_pkg`:
  - Constants NUM_A=16, WIDTH_A=4, OUTWIDTH=4, DEFAULT_SETTLE=3.
  - State enum {LOAD, SETTLE}.
  - Index width $clog2(NUM_A).
- One natural sub-module, `settle_timer`: loadable down-counter with a zero flag, 8-bit.
- All other logic (FSM, slot write decoder, result register) stays in the top module.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> s_ready=1, m_valid=0, inp=64'h0, frame_err=0.
2. Stream s_data=0..15 with s_last on beat 16; cls_in tied to 4'd7 -> inp=64'hFEDCBA9876543210; m_valid rises exactly 4 edges after the final handshake; m_class=7; inp is stable throughout SETTLE.
3. Send s_last on beat 6 -> frame_err pulses for 1 cycle and no m_valid follows. A following full frame of all 4'hA with cls_in=3 -> m_class=3.
4. Hold m_ready=0 after the first result and stream a second frame -> beats 1..15 accepted, s_ready=0 at beat 16, m_class stays 7 while cls_in=2. Pulse m_ready -> final beat accepted next cycle, then m_class=2.
5. Stream 16 beats without s_last -> frame_err pulses at beat 16, idx returns to 0, no SETTLE entry.
6. Assert rst_n=0 in the second SETTLE cycle -> all outputs return to reset values immediately and no m_valid ever appears for that frame.
